// File: rtl/cam_ctrl.sv
// CAM row-array sequencer: one request at a time, owns the row valid mask,
// allocates free rows and priority-encodes search hits into a single response.
module cam_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int IDXW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [WIDTH-1:0] req_data_i,
    input  logic [IDXW-1:0]  req_index_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic             resp_hit_o,
    output logic             resp_err_o,
    output logic [IDXW-1:0]  resp_index_o,
    output logic [WIDTH-1:0] resp_data_o,
    output logic [DEPTH-1:0] arr_we_o,
    output logic [WIDTH-1:0] arr_data_o,
    output logic             arr_search_en_o,
    output logic [WIDTH-1:0] arr_search_data_o,
    input  logic [DEPTH-1:0] arr_match_i,
    output logic [IDXW-1:0]  arr_rd_sel_o,
    input  logic [WIDTH-1:0] arr_rd_data_i,
    output logic [IDXW:0]    count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [1:0]       dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits for ready, and the payload of a raised valid
    // is held unchanged until that transfer.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_SEARCH = 2'b01;
    localparam logic [1:0] OP_READ   = 2'b10;
    localparam logic [1:0] OP_INVAL  = 2'b11;

    state_t state, state_n;

    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [IDXW-1:0]  index_q;
    logic [IDXW-1:0]  alloc_q;
    logic             alloc_ok_q;
    logic [DEPTH-1:0] mask;
    logic [IDXW:0]    count;

    logic             resp_hit;
    logic             resp_err;
    logic [IDXW-1:0]  resp_index;
    logic [WIDTH-1:0] resp_data;

    logic             accept;
    logic [IDXW-1:0]  free_idx;
    logic             free_ok;
    logic [DEPTH-1:0] hits;
    logic [IDXW-1:0]  hit_idx;
    logic             hit_any;
    logic             in_range;
    logic             row_valid;

    assign accept = req_valid_i && (state == IDLE);

    // Lowest free row; sampled at acceptance since the mask cannot move before EXEC.
    always_comb begin
        free_idx = '0;
        free_ok  = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!mask[i]) begin
                free_idx = IDXW'(i);
                free_ok  = 1'b1;
            end
        end
    end

    assign hits = arr_match_i & mask;

    always_comb begin
        hit_idx = '0;
        hit_any = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hits[i]) begin
                hit_idx = IDXW'(i);
                hit_any = 1'b1;
            end
        end
    end

    generate
        if (DEPTH == (1 << IDXW)) begin : g_pow2
            assign in_range = 1'b1;
        end else begin : g_npow2
            assign in_range = {{(32 - IDXW){1'b0}}, index_q} < 32'(DEPTH);
        end
    endgenerate

    assign row_valid = in_range && mask[index_q];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req_valid_i) state_n = EXEC;
            EXEC:    state_n = (op_q == OP_SEARCH || op_q == OP_READ) ? CAPTURE : RESP;
            CAPTURE: state_n = RESP;
            RESP:    if (resp_ready_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q       <= OP_WRITE;
            data_q     <= '0;
            index_q    <= '0;
            alloc_q    <= '0;
            alloc_ok_q <= 1'b0;
            mask       <= '0;
            count      <= '0;
            resp_hit   <= 1'b0;
            resp_err   <= 1'b0;
            resp_index <= '0;
            resp_data  <= '0;
        end else begin
            if (accept) begin
                op_q       <= req_op_i;
                data_q     <= req_data_i;
                index_q    <= req_index_i;
                alloc_q    <= free_idx;
                alloc_ok_q <= free_ok;
            end
            if (state == EXEC) begin
                case (op_q)
                    OP_WRITE: begin
                        resp_hit   <= 1'b0;
                        resp_data  <= '0;
                        resp_err   <= !alloc_ok_q;
                        resp_index <= alloc_ok_q ? alloc_q : '0;
                        if (alloc_ok_q) begin
                            mask[alloc_q] <= 1'b1;
                            count         <= count + (IDXW + 1)'(1);
                        end
                    end
                    OP_INVAL: begin
                        resp_hit   <= 1'b0;
                        resp_data  <= '0;
                        resp_err   <= !in_range;
                        resp_index <= index_q;
                        if (row_valid) begin
                            mask[index_q] <= 1'b0;
                            count         <= count - (IDXW + 1)'(1);
                        end
                    end
                    default: ;
                endcase
            end
            // Array match/read data are settled by CAPTURE, one cycle after EXEC.
            if (state == CAPTURE) begin
                if (op_q == OP_SEARCH) begin
                    resp_hit   <= hit_any;
                    resp_err   <= 1'b0;
                    resp_index <= hit_idx;
                    resp_data  <= '0;
                end else begin
                    resp_hit   <= 1'b0;
                    resp_err   <= !row_valid;
                    resp_index <= index_q;
                    resp_data  <= row_valid ? arr_rd_data_i : '0;
                end
            end
        end
    end

    always_comb begin
        arr_we_o          = '0;
        arr_data_o        = '0;
        arr_search_en_o   = 1'b0;
        arr_search_data_o = '0;
        arr_rd_sel_o      = '0;
        if (state == EXEC && op_q == OP_WRITE && alloc_ok_q) begin
            arr_we_o[alloc_q] = 1'b1;
            arr_data_o        = data_q;
        end
        if ((state == EXEC || state == CAPTURE) && op_q == OP_SEARCH) begin
            arr_search_en_o   = 1'b1;
            arr_search_data_o = data_q;
        end
        if ((state == EXEC || state == CAPTURE) && op_q == OP_READ) begin
            arr_rd_sel_o = index_q;
        end
    end

    assign req_ready_o  = (state == IDLE);
    assign resp_valid_o = (state == RESP);
    assign resp_hit_o   = resp_hit;
    assign resp_err_o   = resp_err;
    assign resp_index_o = resp_index;
    assign resp_data_o  = resp_data;
    assign count_o      = count;
    assign full_o       = (count == (IDXW + 1)'(DEPTH));
    assign empty_o      = (count == '0);
    assign dbg_state_o  = state;

endmodule

// File: tb/tb_cam_ctrl.sv
// Bench for cam_ctrl: array model, directed steps plus randomized traffic
// scored against a row-level reference model of the CAM.
module tb_cam_ctrl;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int IDXW = $clog2(DEPTH);
  localparam int RW = 2 + IDXW + WIDTH;
  localparam logic [1:0] OP_WR = 2'b00;
  localparam logic [1:0] OP_SR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] OP_INV = 2'b11;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid_i = 1'b0;
  logic req_ready_o;
  logic [1:0] req_op_i = 2'b00;
  logic [WIDTH-1:0] req_data_i = '0;
  logic [IDXW-1:0] req_index_i = '0;
  logic resp_valid_o;
  logic resp_ready_i = 1'b0;
  logic resp_hit_o;
  logic resp_err_o;
  logic [IDXW-1:0] resp_index_o;
  logic [WIDTH-1:0] resp_data_o;
  logic [DEPTH-1:0] arr_we_o;
  logic [WIDTH-1:0] arr_data_o;
  logic arr_search_en_o;
  logic [WIDTH-1:0] arr_search_data_o;
  logic [DEPTH-1:0] arr_match_i;
  logic [IDXW-1:0] arr_rd_sel_o;
  logic [WIDTH-1:0] arr_rd_data_i;
  logic [IDXW:0] count_o;
  logic full_o;
  logic empty_o;
  logic [1:0] dbg_state_o;

  int tests = 0;
  int fails = 0;
  logic [RW-1:0] exp_q[$];

  bit ref_v[DEPTH];
  logic [WIDTH-1:0] ref_d[DEPTH];

  // clock / reset
  always #5 clk = ~clk;

  cam_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_data_i(req_data_i), .req_index_i(req_index_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_hit_o(resp_hit_o), .resp_err_o(resp_err_o),
    .resp_index_o(resp_index_o), .resp_data_o(resp_data_o),
    .arr_we_o(arr_we_o), .arr_data_o(arr_data_o),
    .arr_search_en_o(arr_search_en_o), .arr_search_data_o(arr_search_data_o),
    .arr_match_i(arr_match_i), .arr_rd_sel_o(arr_rd_sel_o), .arr_rd_data_i(arr_rd_data_i),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o), .dbg_state_o(dbg_state_o)
  );

  // row array model: keeps stale contents across reset and invalidation
  logic [WIDTH-1:0] mem[DEPTH] = '{default: '0};
  int we_pulses = 0;

  always @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) if (arr_we_o[i]) mem[i] <= arr_data_o;
    if (arr_we_o != '0) we_pulses <= we_pulses + 1;
  end

  always_comb begin
    arr_match_i = '0;
    for (int i = 0; i < DEPTH; i++) arr_match_i[i] = arr_search_en_o && (mem[i] == arr_search_data_o);
  end

  assign arr_rd_data_i = mem[arr_rd_sel_o];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [IDXW:0] ref_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (ref_v[i]) c++;
    return (IDXW + 1)'(c);
  endfunction

  // reference model: operates on rows, returns the packed expected response
  task automatic model(input logic [1:0] op, input logic [WIDTH-1:0] data,
                       input logic [IDXW-1:0] idx, output logic [RW-1:0] e);
    logic hit, err;
    logic [IDXW-1:0] ri;
    logic [WIDTH-1:0] rd;
    int slot;
    hit = 1'b0; err = 1'b0; ri = idx; rd = '0; slot = -1;
    case (op)
      OP_WR: begin
        for (int i = 0; i < DEPTH; i++) if (!ref_v[i]) begin slot = i; break; end
        if (slot < 0) begin
          err = 1'b1; ri = '0;
        end else begin
          ref_v[slot] = 1'b1; ref_d[slot] = data; ri = IDXW'(slot);
        end
      end
      OP_SR: begin
        ri = '0;
        for (int i = 0; i < DEPTH; i++) if (ref_v[i] && ref_d[i] == data) begin slot = i; break; end
        if (slot >= 0) begin hit = 1'b1; ri = IDXW'(slot); end
      end
      OP_RD: begin
        if (int'(idx) >= DEPTH || !ref_v[idx]) err = 1'b1;
        else rd = ref_d[idx];
      end
      default: begin
        if (int'(idx) >= DEPTH) err = 1'b1;
        else ref_v[idx] = 1'b0;
      end
    endcase
    e = {hit, err, ri, rd};
  endtask

  task automatic do_reset();
    req_valid_i = 1'b0;
    resp_ready_i = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) ref_v[i] = 1'b0;
    exp_q.delete();
    reset = 1'b1;
    @(negedge clk);
  endtask

  // driver: one request, response check, optional response backpressure
  task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] data,
                      input logic [IDXW-1:0] idx, input int hold);
    logic [RW-1:0] e;
    logic [RW-1:0] first;
    logic [1:0] st;
    logic [IDXW:0] ecnt;
    int k, we0, exp_we, exp_lat;
    k = 0;
    while (!req_ready_o && k < 50) begin @(negedge clk); k++; end
    chk("req_ready", 64'(req_ready_o), 64'(1));
    model(op, data, idx, e);
    exp_q.push_back(e);
    exp_we = (op == OP_WR && !e[RW-2]) ? 1 : 0;
    exp_lat = (op == OP_WR || op == OP_INV) ? 2 : 3;
    we0 = we_pulses;
    req_valid_i = 1'b1; req_op_i = op; req_data_i = data; req_index_i = idx;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    k = 0;
    @(negedge clk);
    while (!resp_valid_o && k < 20) begin k++; @(negedge clk); end
    chk("latency", 64'(k + 1), 64'(exp_lat));
    first = {resp_hit_o, resp_err_o, resp_index_o, resp_data_o};
    st = dbg_state_o;
    chk("resp", 64'(first), 64'(exp_q.pop_front()));
    chk("arr_idle_in_resp", 64'({arr_we_o, arr_search_en_o, arr_rd_sel_o, |arr_data_o, |arr_search_data_o}), 64'(0));
    chk("we_pulses", 64'(we_pulses - we0), 64'(exp_we));
    ecnt = ref_count();
    chk("count", 64'({count_o, full_o, empty_o}),
        64'({ecnt, ecnt == (IDXW + 1)'(DEPTH), ecnt == '0}));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_stable", 64'({resp_valid_o, req_ready_o, dbg_state_o, resp_hit_o, resp_err_o, resp_index_o, resp_data_o}),
          64'({2'b10, st, first}));
    end
    resp_ready_i = 1'b1;
    @(posedge clk);
    #1 resp_ready_i = 1'b0;
    chk("idle_after", 64'({req_ready_o, resp_valid_o}), 64'(2'b10));
  endtask

  logic [WIDTH-1:0] pool[4];

  initial begin
    pool[0] = 32'h0000_00A5; pool[1] = 32'h1234_5678; pool[2] = 32'hCAFE_F00D; pool[3] = 32'h0;

    // reset values
    do_reset();
    chk("rst_ready_valid", 64'({req_ready_o, resp_valid_o}), 64'(2'b10));
    chk("rst_resp", 64'({resp_hit_o, resp_err_o, resp_index_o, resp_data_o}), 64'(0));
    chk("rst_arr", 64'({arr_we_o, arr_search_en_o, arr_rd_sel_o, |arr_data_o, |arr_search_data_o}), 64'(0));
    chk("rst_count", 64'({count_o, full_o, empty_o}), 64'(2'b01));

    // write then search the same key
    send(OP_WR, 32'hDEAD_BEEF, '0, 0);
    send(OP_SR, 32'hDEAD_BEEF, '0, 0);
    chk("tp1_count", 64'(count_o), 64'(1));

    // allocation reuse and lowest-hit priority
    do_reset();
    for (int i = 0; i < 3; i++) send(OP_WR, 32'hA5, '0, 0);
    send(OP_INV, '0, IDXW'(1), 0);
    send(OP_SR, 32'hA5, '0, 0);
    send(OP_INV, '0, IDXW'(0), 0);
    send(OP_SR, 32'hA5, '0, 1);
    send(OP_WR, 32'h77, '0, 0);
    send(OP_SR, 32'hA5, '0, 0);

    // full array, double invalidate
    do_reset();
    for (int i = 0; i < DEPTH; i++) send(OP_WR, 32'h100 + 32'(i), '0, 0);
    chk("full_flag", 64'({full_o, empty_o}), 64'(2'b10));
    send(OP_WR, 32'hFFFF_0000, '0, 0);
    send(OP_INV, '0, IDXW'(DEPTH - 1), 0);
    send(OP_INV, '0, IDXW'(DEPTH - 1), 0);
    chk("inv_twice_count", 64'(count_o), 64'(DEPTH - 1));
    send(OP_SR, 32'h100 + 32'(DEPTH - 1), '0, 0);

    // reads, stale-row read, search under backpressure
    do_reset();
    send(OP_WR, 32'h11, '0, 0);
    send(OP_WR, 32'h22, '0, 0);
    send(OP_WR, 32'h33, '0, 0);
    send(OP_WR, 32'h1234, '0, 0);
    send(OP_RD, '0, IDXW'(3), 0);
    chk("read3_data", 64'(resp_data_o), 64'(32'h1234));
    send(OP_RD, '0, IDXW'(7), 0);
    send(OP_INV, '0, IDXW'(2), 0);
    send(OP_RD, '0, IDXW'(2), 2);
    send(OP_SR, 32'h22, '0, 5);

    // randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < 250; n++) begin
      logic [1:0] op;
      int r;
      r = $urandom_range(0, 9);
      op = (r < 4) ? OP_WR : (r < 6) ? OP_SR : (r < 8) ? OP_RD : OP_INV;
      send(op, pool[$urandom_range(0, 3)], IDXW'($urandom_range(0, DEPTH - 1)), $urandom_range(0, 2));
    end

    // reset dropped during EXEC of a write
    do_reset();
    send(OP_WR, 32'h5555, '0, 0);
    send(OP_WR, 32'h6666, '0, 0);
    @(negedge clk);
    req_valid_i = 1'b1; req_op_i = OP_WR; req_data_i = 32'h7777;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    chk("we_in_exec", 64'(arr_we_o), 64'(16'h0004));
    reset = 1'b0;
    #1;
    chk("rst_mid", 64'({arr_we_o, count_o, resp_valid_o, req_ready_o, empty_o}), 64'(3'b011));
    for (int i = 0; i < DEPTH; i++) ref_v[i] = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(OP_SR, 32'h5555, '0, 0);
    send(OP_WR, 32'h8888, '0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cam_ctrl.md
# cam_ctrl

Sequencing controller for the CAM row array: accepts one request at a time from a single client and drives the shared write/search/read buses of DEPTH row instances. It owns the authoritative per-row valid mask, allocates free rows, and priority-encodes search hits. It also returns one response per request through a valid/ready handshake. It sits between the client logic and the row array.

## Interface
- WIDTH, 32, data/key width per row
- DEPTH, 16, number of rows (2..256); IDXW = $clog2(DEPTH), derived, not overridable
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- req_valid_i  in  1  request present
- req_ready_o  out  1  controller can accept (high only in IDLE)
- req_op_i  in  2  00 WRITE, 01 SEARCH, 10 READ, 11 INVALIDATE
- req_data_i  in  WIDTH  write data / search key
- req_index_i  in  IDXW  row index for READ/INVALIDATE
- resp_valid_o  out  1  response present
- resp_ready_i  in  1  client accepts response
- resp_hit_o  out  1  SEARCH found a valid match
- resp_err_o  out  1  WRITE to full array, or READ/INVALIDATE of index >= DEPTH, or READ of invalid row
- resp_index_o  out  IDXW  allocated row (WRITE), lowest matching row (SEARCH), echoed index otherwise
- resp_data_o  out  WIDTH  row contents (READ), else 0
- arr_we_o  out  DEPTH  one-hot per-row write enable
- arr_data_o  out  WIDTH  shared write data
- arr_search_en_o  out  1  shared search enable
- arr_search_data_o  out  WIDTH  shared search key
- arr_match_i  in  DEPTH  per-row match from array
- arr_rd_sel_o  out  IDXW  row select for read mux
- arr_rd_data_i  in  WIDTH  muxed row data
- count_o  out  IDXW+1  number of valid rows
- full_o / empty_o  out  1  count_o == DEPTH / count_o == 0

## Operation
- States: IDLE, EXEC, CAPTURE, RESP. Request accepted when req_valid_i & req_ready_o; op, data, index registered on acceptance.
- IDLE -> EXEC on acceptance. EXEC -> RESP for WRITE/INVALIDATE; EXEC -> CAPTURE for SEARCH/READ. CAPTURE -> RESP. RESP -> IDLE when resp_ready_i.
- WRITE: target is the lowest row with mask bit 0, computed at acceptance. In EXEC: arr_we_o bit set for exactly one cycle, mask bit set, count +1. If full: no write, err=1, index=0.
- SEARCH: arr_search_en_o high in EXEC and CAPTURE; arr_search_data_o held stable from EXEC through CAPTURE. In CAPTURE, arr_match_i & mask is sampled. Lowest set bit gives resp_index_o and hit=1. If none: hit=0, index=0.
- READ: arr_rd_sel_o = index from EXEC through CAPTURE; arr_rd_data_i sampled in CAPTURE. Invalid row or out of range: err=1, data=0.
- INVALIDATE: clears mask bit in EXEC, count -1 only if the bit was set. Invalidating an already-invalid row is not an error. Out of range: err=1, no change. Array contents are untouched; stale data is masked from hits and overwritten on reallocation.
- Response fields registered, stable while resp_valid_o is high and resp_ready_i is low.
- All arr_* outputs are 0 outside the states listed above.

## Timing
- Reset values: req_ready_o=1, resp_valid_o=0, resp_hit_o=0, resp_err_o=0, resp_index_o=0, resp_data_o=0, arr_we_o=0, arr_search_en_o=0, arr_search_data_o=0, arr_data_o=0, arr_rd_sel_o=0, mask=0, count_o=0, empty_o=1, full_o=0.
- Acceptance edge is cycle 0. resp_valid_o rises at cycle 2 for WRITE/INVALIDATE and at cycle 3 for SEARCH/READ, given no backpressure.
- Minimum accept-to-accept spacing is 3 cycles for WRITE/INVALIDATE and 4 for SEARCH/READ, since req_ready_o is low from EXEC through RESP.
- The array must present match and read data combinationally or with ≤1 cycle latency relative to EXEC.
- Reset asserted mid-operation: in-flight response dropped, any pending write enable removed immediately, mask cleared. The array's own contents are not the controller's concern.

## Test plan
- After reset, WRITE 0xDEADBEEF, then SEARCH 0xDEADBEEF -> write resp index=0 err=0 at cycle 2; search hit=1 index=0 at cycle 3; count_o=1.
- WRITE 0xA5 to rows 0..2, INVALIDATE 1, SEARCH 0xA5 -> hit index 0. Then INVALIDATE 0, SEARCH 0xA5 -> index 2. Next WRITE 0x77 allocates row 0.
- Fill all 16 rows, then WRITE -> err=1, full_o=1, arr_we_o stays 0. INVALIDATE 15 twice -> count_o 15 both times, both err=0.
- READ index 3 after writing 0x1234 there -> data=0x1234 at cycle 3. READ an invalid row -> err=1, data=0.
- Hold resp_ready_i low 5 cycles on a SEARCH -> resp fields stable, req_ready_o=0 throughout. Drop reset during EXEC of a WRITE -> arr_we_o falls immediately, count_o=0, resp_valid_o=0.
